// File: rtl/lsu.sv
// Load/store unit: one request at a time through IDLE -> ACCESS -> RESP.
// Faulting requests go straight to RESP and never touch memory.
module lsu #(
  parameter int ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wrdata,
  output logic [3:0]  mem_wrstb,
  input  logic [31:0] mem_rddata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [32:0] LIMIT = 33'(ADDR_LIMIT);

  state_t      state;
  logic        we_q, sgn_q;
  logic [1:0]  size_q, lo_q;
  logic        fault;
  logic [3:0]  strb;
  logic [31:0] wrdata, shifted, ldata;

  always_comb begin
    fault = 1'b0;
    case (req_size)
      2'b01:   fault = req_addr[0];
      2'b10:   fault = |req_addr[1:0];
      2'b11:   fault = 1'b1;
      default: fault = 1'b0;
    endcase
    if ({1'b0, req_addr} >= LIMIT) fault = 1'b1;
  end

  // Lane strobes and lane-replicated data are built from the live request
  // so they can be registered straight into the ACCESS cycle.
  always_comb begin
    case (req_size)
      2'b00:   begin strb = 4'b0001 << req_addr[1:0]; wrdata = {4{req_wdata[7:0]}};  end
      2'b01:   begin strb = 4'b0011 << req_addr[1:0]; wrdata = {2{req_wdata[15:0]}}; end
      default: begin strb = 4'b1111;                  wrdata = req_wdata;            end
    endcase
  end

  always_comb begin
    shifted = mem_rddata >> {lo_q, 3'b000};
    case (size_q)
      2'b00:   ldata = sgn_q ? {{24{shifted[7]}},  shifted[7:0]}  : {24'b0, shifted[7:0]};
      2'b01:   ldata = sgn_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
      default: ldata = shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_fault  <= 1'b0;
      mem_addr   <= '0;
      mem_wrdata <= '0;
      mem_wrstb  <= '0;
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= '0;
      lo_q       <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q      <= req_we;
          sgn_q     <= req_signed;
          size_q    <= req_size;
          lo_q      <= req_addr[1:0];
          req_ready <= 1'b0;
          if (fault) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            state      <= ACCESS;
            mem_addr   <= {req_addr[31:2], 2'b00};
            mem_wrdata <= wrdata;
            mem_wrstb  <= req_we ? strb : 4'b0000;
          end
        end
        ACCESS: begin
          state     <= RESP;
          mem_wrstb <= 4'b0000;
          rsp_valid <= 1'b1;
          rsp_fault <= 1'b0;
          rsp_rdata <= we_q ? 32'b0 : ldata;
        end
        RESP: if (rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: byte-array reference model + per-cycle compare process,
// driven by directed requests that carry hand-computed expectations.
module tb_lsu;
  logic        clk, rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [31:0] rsp_rdata, mem_addr, mem_wrdata, mem_rddata;
  logic [3:0]  mem_wrstb;

  lsu #(.ADDR_LIMIT(1024)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault), .mem_addr(mem_addr),
    .mem_wrdata(mem_wrdata), .mem_wrstb(mem_wrstb), .mem_rddata(mem_rddata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_hs = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Data memory seen by the DUT, written only through its strobes.
  bit [7:0]   dmem [1024];
  logic [9:0] wa;
  assign wa = {mem_addr[9:2], 2'b00};
  assign mem_rddata = {dmem[wa + 10'd3], dmem[wa + 10'd2], dmem[wa + 10'd1], dmem[wa]};
  always @(posedge clk)
    for (int j = 0; j < 4; j++)
      if (mem_wrstb[j]) dmem[{mem_addr[9:2], 2'(j)}] <= mem_wrdata[8*j +: 8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: byte-addressed memory plus expected responses/strobes.
  typedef struct { logic [31:0] rdata; logic fault; int due; } exp_t;
  typedef struct { logic [31:0] addr, data; logic [3:0] strb; int due; } st_t;
  bit [7:0] refmem [1024];
  exp_t eq[$];
  st_t  sq[$];
  bit   head_seen = 0;

  task automatic model_push();
    exp_t e; st_t s; int a, n; logic [31:0] v; logic flt;
    n = 1 << req_size;
    flt = (req_size == 2'b11) || (req_size == 2'b01 && req_addr % 2 != 0) ||
          (req_size == 2'b10 && req_addr % 4 != 0) || (req_addr >= 32'd1024);
    e.rdata = 32'b0; e.fault = flt; e.due = cyc + (flt ? 1 : 2);
    if (!flt) begin
      a = int'(req_addr[9:0]);
      if (req_we) begin
        s.strb = 4'b0;
        for (int i = 0; i < n; i++) begin
          refmem[a+i] = req_wdata[8*i +: 8];
          s.strb[(a+i)%4] = 1'b1;
        end
        for (int j = 0; j < 4; j++) s.data[8*j +: 8] = req_wdata[8*(j%n) +: 8];
        s.addr = req_addr & ~32'h3;
        s.due  = cyc + 1;
        sq.push_back(s);
      end else begin
        v = 32'b0;
        for (int i = 0; i < n; i++) v = v | (32'(refmem[a+i]) << (8*i));
        if (req_signed && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        e.rdata = v;
      end
    end
    eq.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        eq.delete(); sq.delete(); head_seen = 0;
      end else begin
        if (mem_wrstb != 4'b0) begin
          if (sq.size() == 0) chk("stray_strobe", 32'(mem_wrstb), 32'b0);
          else begin
            chk("strobe_cycle", 32'(cyc), 32'(sq[0].due));
            chk("mem_addr", mem_addr, sq[0].addr);
            chk("mem_wrdata", mem_wrdata, sq[0].data);
            chk("mem_wrstb", 32'(mem_wrstb), 32'(sq[0].strb));
            void'(sq.pop_front());
          end
        end else if (sq.size() != 0 && cyc >= sq[0].due) begin
          chk("mem_wrstb_missing", 32'(mem_wrstb), 32'(sq[0].strb));
          void'(sq.pop_front());
        end
        if (rsp_valid) begin
          chk("req_ready_in_resp", 32'(req_ready), 32'b0);
          chk("wrstb_in_resp", 32'(mem_wrstb), 32'b0);
          if (eq.size() == 0) chk("stray_rsp", 32'(rsp_valid), 32'b0);
          else begin
            if (!head_seen) begin
              chk("rsp_latency", 32'(cyc), 32'(eq[0].due));
              head_seen = 1;
            end
            chk("rsp_rdata", rsp_rdata, eq[0].rdata);
            chk("rsp_fault", 32'(rsp_fault), 32'(eq[0].fault));
            if (rsp_ready) begin void'(eq.pop_front()); head_seen = 0; end
          end
        end else if (eq.size() != 0 && !head_seen && cyc >= eq[0].due) begin
          chk("rsp_valid_due", 32'(rsp_valid), 32'd1);
          void'(eq.pop_front());
        end
        if (req_valid && req_ready) model_push();
      end
    end
  end

  // One request with literal expectations; es=0 means no strobe expected.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ef, input logic [3:0] es,
                        input logic [31:0] ema, input logic [31:0] ewd, input int hold);
    int n;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    last_hs = cyc;
    req_valid = 1'b0;
    chk("access_strobe", 32'(mem_wrstb), 32'(es));
    if (es != 4'b0) begin
      chk("access_addr", mem_addr, ema);
      chk("access_wrdata", mem_wrdata, ewd);
    end
    n = 0;
    while (!rsp_valid && n < 5) begin @(posedge clk); #1; n++; end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("lit_rdata", rsp_rdata, er);
    chk("lit_fault", 32'(rsp_fault), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, er);
      chk("hold_req_ready", 32'(req_ready), 32'b0);
      chk("hold_wrstb", 32'(mem_wrstb), 32'b0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("back_to_idle", 32'(req_ready), 32'd1);
    chk("rsp_dropped", 32'(rsp_valid), 32'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  int h0;
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'b0);
    chk("rst_rsp_rdata", rsp_rdata, 32'b0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'b0);
    chk("rst_mem_addr", mem_addr, 32'b0);
    chk("rst_mem_wrdata", mem_wrdata, 32'b0);
    chk("rst_mem_wrstb", 32'(mem_wrstb), 32'b0);
    rst = 1'b0;

    // stores that seed memory
    do_req(1, 2'b00, 0, 32'h6,  32'h0000_00A5, 32'h0, 0, 4'b0100, 32'h4,  32'hA5A5_A5A5, 0);
    do_req(1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 32'h0, 0, 4'b1111, 32'h10, 32'h80FF_7F01, 0);
    do_req(1, 2'b01, 0, 32'h1A, 32'h1234_BEEF, 32'h0, 0, 4'b1100, 32'h18, 32'hBEEF_BEEF, 0);
    // loads with extension
    do_req(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b01, 0, 32'h12, 32'h0, 32'h0000_80FF, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b01, 1, 32'h10, 32'h0, 32'h0000_7F01, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b00, 0, 32'h11, 32'h0, 32'h0000_007F, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b00, 1, 32'h12, 32'h0, 32'hFFFF_FFFF, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b00, 1, 32'h6,  32'h0, 32'hFFFF_FFA5, 0, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b01, 1, 32'h1A, 32'h0, 32'hFFFF_BEEF, 0, 4'b0, 32'h0, 32'h0, 0);
    // faults
    do_req(0, 2'b10, 0, 32'h2,   32'h0,         32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b01, 0, 32'h1,   32'h0,         32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b11, 0, 32'h0,   32'h0,         32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    do_req(0, 2'b10, 0, 32'h400, 32'h0,         32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    do_req(1, 2'b10, 0, 32'h400, 32'hFFFF_FFFF, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    do_req(1, 2'b01, 0, 32'h3,   32'hFFFF_FFFF, 32'h0, 1, 4'b0, 32'h0, 32'h0, 0);
    // top edge of the window
    do_req(1, 2'b00, 0, 32'h3FF, 32'h0000_005A, 32'h0, 0, 4'b1000, 32'h3FC, 32'h5A5A_5A5A, 0);
    do_req(0, 2'b00, 1, 32'h3FF, 32'h0, 32'h0000_005A, 0, 4'b0, 32'h0, 32'h0, 0);
    // backpressure
    rsp_ready = 1'b0;
    do_req(0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FF80, 0, 4'b0, 32'h0, 32'h0, 5);
    // back-to-back word loads
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'h80FF_7F01, 0, 4'b0, 32'h0, 32'h0, 0);
    h0 = last_hs;
    do_req(0, 2'b10, 0, 32'h18, 32'h0, 32'hBEEF_0000, 0, 4'b0, 32'h0, 32'h0, 0);
    chk("b2b_gap1", 32'(last_hs - h0), 32'd3);
    h0 = last_hs;
    do_req(0, 2'b10, 0, 32'h4,  32'h0, 32'h00A5_0000, 0, 4'b0, 32'h0, 32'h0, 0);
    chk("b2b_gap2", 32'(last_hs - h0), 32'd3);

    // reset in the middle of a word store's ACCESS cycle
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
    req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort_strobe_on", 32'(mem_wrstb), 32'hF);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobe_drop", 32'(mem_wrstb), 32'b0);
    chk("abort_rsp_valid", 32'(rsp_valid), 32'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'b0);
    chk("post_rst_req_ready", 32'(req_ready), 32'd1);
    do_req(0, 2'b10, 0, 32'h10, 32'h0, 32'h80FF_7F01, 0, 4'b0, 32'h0, 32'h0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("pending_rsp", 32'(eq.size()), 32'b0);
    chk("pending_strobe", 32'(sq.size()), 32'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 1024, meaning the byte size of the data memory window; addresses at or above it fault.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1, meaning the pipeline presents a load or store.
REQ-005 SHALL have port req_ready, output, 1, meaning the LSU accepts the request this cycle.
REQ-006 SHALL have port req_we, input, 1, meaning 1 = store and 0 = load.
REQ-007 SHALL have port req_size, input, 2, meaning 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed, input, 1, meaning sign-extend load data.
REQ-009 SHALL have port req_addr, input, u32_t, the byte address.
REQ-010 SHALL have port req_wdata, input, u32_t, store data right-justified.
REQ-011 SHALL have port rsp_valid, output, 1, meaning the response is available.
REQ-012 SHALL have port rsp_ready, input, 1, meaning the consumer takes the response.
REQ-013 SHALL have port rsp_rdata, output, u32_t, the extended load data.
REQ-014 SHALL have port rsp_fault, output, 1, meaning a misaligned, illegal-size or out-of-range access.
REQ-015 SHALL have port mem_addr, output, u32_t, the word-aligned address to the data memory.
REQ-016 SHALL have port mem_wrdata, output, u32_t, the lane-replicated store data.
REQ-017 SHALL have port mem_wrstb, output, wrstb_t, the per-byte write strobes.
REQ-018 SHALL have port mem_rddata, input, u32_t, the combinational word read from the data memory.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS and RESP.
REQ-020 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&&req_ready.
REQ-021 SHALL register we, size, signed, addr and wdata on handshake; inputs are ignored otherwise.
REQ-022 SHALL fault when any of these holds: size==11; half with addr[0]==1; word with addr[1:0]!=00; addr>=ADDR_LIMIT.
REQ-023 SHALL, on a non-faulting handshake, go IDLE->ACCESS; on a faulting handshake, go IDLE->RESP with rsp_fault=1, rsp_rdata=0 and no memory strobe.
REQ-024 SHALL, in ACCESS, drive mem_addr={addr[31:2],2'b00}.
REQ-025 SHALL, for stores in ACCESS, drive mem_wrstb as follows: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-026 SHALL drive mem_wrdata with the byte replicated x4, the half replicated x2, or the word unchanged.
REQ-027 SHALL, for loads in ACCESS, capture mem_rddata>>(8*addr[1:0]); take the low 8/16/32 bits; sign-extend if signed, else zero-extend; mem_wrstb=0.
REQ-028 SHALL return rsp_rdata=0 for stores.
REQ-029 SHALL always go ACCESS->RESP after exactly one cycle.
REQ-030 SHALL give latency: handshake at edge N, ACCESS during cycle N+1, rsp_valid=1 from cycle N+2.
REQ-031 SHALL, in RESP, hold rsp_valid, rsp_rdata and rsp_fault stable until rsp_valid&&rsp_ready, then go to IDLE; req_ready stays 0 until IDLE.
REQ-032 SHALL, outside ACCESS, hold mem_wrstb=0000; mem_addr and mem_wrdata hold their last values.
REQ-033 SHALL never assert more than one ACCESS cycle per request; a stalled rsp_ready never re-strobes memory.
REQ-034 SHALL allow back-to-back requests at a maximum of one per 3 cycles with rsp_ready tied high.

Reset
REQ-035 SHALL, while rst=1, hold: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0, mem_addr=0, mem_wrdata=0, mem_wrstb=0000.
REQ-036 SHALL, if rst asserts in ACCESS or RESP, abort the transaction: any strobe deasserts immediately (asynchronously) and the pending response is discarded.
REQ-037 SHALL accept a new request in the first cycle after rst deasserts.

Verification
REQ-038 SHALL cover a byte store: addr 0x0000_0006, wdata 0x0000_00A5 -> mem_addr 0x4, wrdata 0xA5A5A5A5, wrstb 0100 for exactly one cycle; rsp fault=0 at N+2.
REQ-039 SHALL cover signed byte and half loads: mem word 0x80FF_7F01; signed byte at addr 3 -> 0xFFFF_FF80; unsigned half at addr 2 -> 0x0000_80FF; signed half at addr 0 -> 0x0000_7F01.
REQ-040 SHALL cover faults: word at addr 0x2, half at 0x1, size 11, and word at 0x400 (ADDR_LIMIT=1024) -> each gives rsp_fault=1, rsp_rdata=0, wrstb never nonzero.
REQ-041 SHALL cover backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, wrstb=0000 throughout; release -> IDLE the next cycle.
REQ-042 SHALL cover reset during a word store in ACCESS: wrstb drops to 0000 immediately; after release, rsp_valid=0 and req_ready=1.
REQ-043 SHALL cover three back-to-back word loads with rsp_ready=1 -> handshakes 3 cycles apart with correct data each.
